// File: rtl/shift_register_parallel_load_serial_out_if.sv
// rtl/shift_register_parallel_load_serial_out_if.sv - load and serial-stream signal bundle for the serializer
interface shift_register_parallel_load_serial_out_if #(
   parameter int W = 16
);
   logic         load_valid;
   logic [W-1:0] inp_reg;
   logic         load_ready;
   logic         shift_enable;
   logic         serial_out;
   logic         serial_valid;
   logic         last_bit;
   logic         busy;
   logic         done;

   modport master (
      output load_valid, inp_reg, shift_enable,
      input  load_ready, serial_out, serial_valid, last_bit, busy, done
   );

   modport slave (
      input  load_valid, inp_reg, shift_enable,
      output load_ready, serial_out, serial_valid, last_bit, busy, done
   );
endinterface

// File: rtl/shift_register_parallel_load_serial_out.sv
// rtl/shift_register_parallel_load_serial_out.sv - parallel-load, serial-out shift register with IDLE/SHIFT/DONE control
module shift_register_parallel_load_serial_out #(
   parameter int W         = 16,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic                                  clk,
   input  logic                                  reset_asynchronous,
   shift_register_parallel_load_serial_out_if.slave bus
);
   localparam int            CW       = (W > 1) ? $clog2(W) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(W - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [W-1:0]  sr_q, sr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          at_last;
   logic          out_bit;

   always_ff @(posedge clk or posedge reset_asynchronous) begin
      if (reset_asynchronous) begin
         state_q <= IDLE;
         sr_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         sr_q    <= sr_d;
         cnt_q   <= cnt_d;
      end
   end

   assign at_last = (cnt_q == LAST_CNT);

   always_comb begin
      state_d = state_q;
      sr_d    = sr_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (bus.load_valid) begin
               sr_d    = bus.inp_reg;
               cnt_d   = '0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            // Vacated positions fill with zero; stalled cycles leave everything untouched.
            if (bus.shift_enable) begin
               sr_d  = MSB_FIRST ? (sr_q << 1) : (sr_q >> 1);
               cnt_d = cnt_q + CW'(1);
               if (at_last) begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // All outputs decode from registered state so reset reaches them without a clock.
   assign out_bit          = MSB_FIRST ? sr_q[W-1] : sr_q[0];
   assign bus.load_ready   = (state_q == IDLE);
   assign bus.serial_valid = (state_q == SHIFT);
   assign bus.serial_out   = (state_q == SHIFT) && out_bit;
   assign bus.last_bit     = (state_q == SHIFT) && at_last;
   assign bus.busy         = (state_q != IDLE);
   assign bus.done         = (state_q == DONE);
endmodule

// File: doc/shift_register_parallel_load_serial_out.md
SHIFT_REGISTER_PARALLEL_LOAD_SERIAL_OUT -- requirements
Module: shift_register_parallel_load_serial_out

Interface
REQ-001 Parameter W SHALL default to 16 and set the parallel word width (W >= 1).
REQ-002 Parameter MSB_FIRST SHALL default to 1: 1 = bit W-1 sent first, 0 = bit 0 sent first.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset_asynchronous  input  1  SHALL be an asynchronous, active-high reset that clears all state immediately, independent of clk.
REQ-005 load_valid  input  1  SHALL request capture of inp_reg.
REQ-006 inp_reg  input  W  SHALL carry the parallel word to serialize.
REQ-007 load_ready  output  1  SHALL indicate the block accepts a load this cycle.
REQ-008 shift_enable  input  1  SHALL be the consumer's take-bit strobe; low = stall.
REQ-009 serial_out  output  1  SHALL present the current bit.
REQ-010 serial_valid  output  1  SHALL qualify serial_out.
REQ-011 last_bit  output  1  SHALL mark the final bit of the word.
REQ-012 busy  output  1  SHALL be high whenever the state is not IDLE.
REQ-013 done  output  1  SHALL pulse for one cycle after the last bit is consumed.

Function
REQ-014 FSM SHALL have exactly three states: IDLE, SHIFT, DONE.
REQ-015 IDLE: load_ready=1; on an edge with load_valid=1, capture inp_reg into the shift register, clear the bit counter, go to SHIFT.
REQ-016 Load handshake SHALL complete on an edge where load_valid=1 and load_ready=1; the first bit is valid the following cycle (latency 1).
REQ-017 SHIFT: serial_valid=1; serial_out = shift register bit W-1 (MSB_FIRST=1) or bit 0 (MSB_FIRST=0), driven combinationally from the register.
REQ-018 SHIFT, edge with shift_enable=1: shift register moves one position toward the output end, vacated bit filled with 0, counter increments.
REQ-019 SHIFT, edge with shift_enable=0: shift register, counter and serial_out SHALL hold.
REQ-020 last_bit SHALL be 1 iff state is SHIFT and counter equals W-1.
REQ-021 SHIFT, edge with shift_enable=1 and last_bit=1: go to DONE.
REQ-022 DONE: done=1, load_ready=0, serial_valid=0; unconditionally go to IDLE next edge.
REQ-023 Minimum word period with shift_enable held high SHALL be W+2 cycles (load, W bits, DONE).
REQ-024 load_valid outside IDLE SHALL be ignored; no capture, no effect on the transfer in progress.
REQ-025 Changes on inp_reg after capture SHALL NOT affect serial_out.
REQ-026 shift_enable outside SHIFT SHALL be ignored.
REQ-027 Counter width SHALL be max(1, ceil(log2 W)); W=1 sends one bit with last_bit=1 on its only SHIFT cycle.
REQ-028 serial_out SHALL be 0 whenever serial_valid=0.

Reset
REQ-029 Asserting reset_asynchronous SHALL force, without waiting for clk: state IDLE, shift register 0, counter 0, serial_out=0, serial_valid=0, last_bit=0, busy=0, done=0, load_ready=1.
REQ-030 Reset mid-transfer SHALL abandon the word; no done pulse; the next load after deassertion SHALL behave as from power-up.
REQ-031 Outputs SHALL hold reset values while reset_asynchronous=1, regardless of load_valid or shift_enable.

Verification
REQ-032 W=16, MSB_FIRST=1, load 0xA5C3, shift_enable=1 always -> serial_out 1010010111000011 on cycles 1..16 after load, last_bit on cycle 16, done on cycle 17, load_ready=1 on cycle 18.
REQ-033 Same word, shift_enable low for 3 cycles at bit 5 -> bit 5 held with serial_valid=1 for 4 cycles, stream otherwise identical, done at cycle 20.
REQ-034 MSB_FIRST=0, load 0x0001 -> serial_out 1 on cycle 1, 0 on cycles 2..16.
REQ-035 During SHIFT drive load_valid=1 with inp_reg=0xFFFF -> load_ready=0, stream of the original word unchanged.
REQ-036 Assert reset_asynchronous between clock edges at bit 8 -> busy, serial_valid and serial_out drop to 0 before the next edge; no done pulse; load of 0x8000 afterwards gives 1 then fifteen 0s.
REQ-037 W=1, load 1 -> one SHIFT cycle with serial_out=1, last_bit=1, then done, then IDLE.
